sram_port_ctrl: RTL and testbench
=================================

Name: sram_port_ctrl

Overview:
Initiator for one RW port of the OpenRAM-style sram_*_freepdk45 macros. It converts a valid/ready request stream into csb/web/addr/din port cycles. It also captures dout at the correct edge and returns read data in order on a valid/ready response stream through a small response FIFO. One instance drives each SRAM port in the accelerator memory hierarchy.

Parameters:
DATA_WIDTH, 128, word width; matches SRAM din/dout.
ADDR_WIDTH, 11, SRAM address width.
NUM_WORDS, 1296, populated words; addresses >= NUM_WORDS are out of range.
RSP_DEPTH, 4, response FIFO entries; minimum 2, and 4 gives full read throughput.

Ports:
clk  in  1  clock; connects to the SRAM clk port.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request valid.
req_ready  out  1  request accepted when valid && ready at posedge.
req_we  in  1  1 = write, 0 = read.
req_addr  in  ADDR_WIDTH  word address.
req_wdata  in  DATA_WIDTH  write data.
rsp_valid  out  1  read response valid.
rsp_ready  in  1  response consumer ready.
rsp_rdata  out  DATA_WIDTH  read data.
rsp_err  out  1  response belongs to an out-of-range read; rsp_rdata = 0.
err_sticky  out  1  set by any out-of-range request; cleared only by reset.
sram_csb  out  1  to SRAM csb (active-low select).
sram_web  out  1  to SRAM web (active-low write).
sram_addr  out  ADDR_WIDTH  to SRAM addr.
sram_din  out  DATA_WIDTH  to SRAM din.
sram_dout  in  DATA_WIDTH  from SRAM dout.
stat_rd_cnt  out  32  reads issued (optional feature).
stat_wr_cnt  out  32  writes issued (optional feature).
stat_stall_cnt  out  32  cycles with req_valid && !req_ready (optional feature).

Behaviour:
- Reset values (async on rst_n=0): sram_csb=1, sram_web=1, sram_addr=0, sram_din=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, err_sticky=0, FIFO empty, pipeline empty, stat counters 0.
- Reset asserted mid-operation discards in-flight reads and FIFO contents. No responses are produced for them.
- All sram_* outputs are registered and are driven from flops only.
- Issue, acceptance at edge T0:
  - In-range request: sram_csb=0, sram_web=~req_we, sram_addr/sram_din loaded, all valid during cycle T0..T1.
  - No acceptance at T0: sram_csb=1 and sram_web=1 for that cycle. addr/din hold their previous values.
- Read pipeline: stage A (driven, T0..T1), stage B (SRAM latched at T1, dout settles after the T1 negedge). At edge T2 the controller captures sram_dout into the FIFO tail.
  - Minimum latency: acceptance edge T0 to rsp_valid=1 in the cycle after T2, i.e. 2 cycles.
- Out-of-range request (addr >= NUM_WORDS):
  - Accepted normally; sram_csb stays 1 for that slot; err_sticky sets at T0.
  - A read still traverses stages A and B, then enqueues data 0 with err=1 at T2, preserving order.
  - A write is dropped.
- Credits: reads_in_flight = stage A reads + stage B reads (0..2).
  - req_ready = (fifo_count + reads_in_flight) < RSP_DEPTH, independent of req_we and req_valid. Writes consume the same credit check but never enqueue.
- Response FIFO:
  - First-word-fall-through: rsp_valid = !empty; head entry on rsp_rdata/rsp_err.
  - Pop on rsp_valid && rsp_ready.
  - Simultaneous push and pop on a full FIFO is legal; the credit rule guarantees no push into a full FIFO without a pop.
  - Pointers wrap modulo RSP_DEPTH.
- Ordering: responses return strictly in request order. Writes followed by reads to the same address return new data, because the SRAM writes at the negedge of the cycle it latched.
- Backpressure: with rsp_ready=0 the controller accepts at most RSP_DEPTH reads, then req_ready=0 until a pop.

Optional Feature:
SRAM_CTRL_STATS_EN:
- Defined: stat_rd_cnt increments per issued in-range read; stat_wr_cnt per issued in-range write; stat_stall_cnt per cycle with req_valid && !req_ready. All three are 32-bit, saturate at 0xFFFFFFFF, and reset to 0.
- Undefined: the three ports are tied to 0 and no counter flops are inferred.

Test Plan:
- Reset, no traffic -> sram_csb=1, sram_web=1, rsp_valid=0, req_ready=1, err_sticky=0.
- Write addr 5 data 0xA5..A5, then read addr 5 on the next cycle, rsp_ready=1 -> one write port cycle (csb=0, web=0); read rsp_rdata=0xA5..A5, rsp_err=0, rsp_valid exactly 2 cycles after read acceptance.
- 8 back-to-back reads addr 0..7 (preloaded mem[i]=i), rsp_ready=1 -> req_ready never drops, 8 responses 0..7 in order on consecutive cycles.
- Same 8 reads with rsp_ready=0 -> req_ready falls after 4 acceptances. Release rsp_ready -> remaining reads are accepted and all 8 return in order with none lost.
- Read addr 1300 (NUM_WORDS=1296) -> sram_csb stays 1; response rdata=0, rsp_err=1; err_sticky=1. A following write to 1300 leaves mem unchanged.
- rst_n pulsed low with 2 reads in flight and 2 in the FIFO -> all outputs return to reset values immediately; no responses after release. With SRAM_CTRL_STATS_EN, counters read 0.

Source files
------------

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: valid/ready initiator for one OpenRAM-style RW port.
// Optional SRAM_CTRL_STATS_EN adds saturating rd/wr/stall counters.
module sram_port_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_WORDS  = 1296,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  err_sticky,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic [31:0]           stat_rd_cnt,
  output logic [31:0]           stat_wr_cnt,
  output logic [31:0]           stat_stall_cnt
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int SW = CW + 2;
  localparam logic [ADDR_WIDTH:0] NW = (ADDR_WIDTH + 1)'(NUM_WORDS);
  localparam logic [PW-1:0] PMAX = PW'(RSP_DEPTH - 1);
  localparam logic [SW-1:0] DEPTH_S = SW'(RSP_DEPTH);

  logic                  in_range;
  logic                  accept;
  logic                  rd_acc;
  logic                  push;
  logic                  pop;
  logic [SW-1:0]         used;

  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  a_vld_q, a_vld_d;
  logic                  a_err_q, a_err_d;
  logic                  b_vld_q, b_vld_d;
  logic                  b_err_q, b_err_d;
  logic                  err_q, err_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         wr_q, wr_d;
  logic [PW-1:0]         rd_q, rd_d;
  logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
  logic [RSP_DEPTH-1:0]  merr_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PMAX) ? '0 : p + 1'b1;
  endfunction

  // Credits cover FIFO occupancy plus reads still in the SRAM pipe.
  assign in_range = {1'b0, req_addr} < NW;
  assign used     = SW'(cnt_q) + SW'(a_vld_q) + SW'(b_vld_q);
  assign req_ready = used < DEPTH_S;
  assign accept   = req_valid & req_ready;
  assign rd_acc   = accept & ~req_we;
  assign push     = b_vld_q;
  assign rsp_valid = cnt_q != '0;
  assign pop      = rsp_valid & rsp_ready;

  assign rsp_rdata  = rsp_valid ? mem_q[rd_q] : '0;
  assign rsp_err    = rsp_valid & merr_q[rd_q];
  assign err_sticky = err_q;
  assign sram_csb   = csb_q;
  assign sram_web   = web_q;
  assign sram_addr  = addr_q;
  assign sram_din   = din_q;

  // Port drive: select only for accepted in-range requests.
  always_comb begin
    csb_d  = 1'b1;
    web_d  = 1'b1;
    addr_d = addr_q;
    din_d  = din_q;
    if (accept) begin
      addr_d = req_addr;
      din_d  = req_wdata;
      if (in_range) begin
        csb_d = 1'b0;
        web_d = ~req_we;
      end
    end
  end

  // Read pipe stages A/B and sticky error.
  always_comb begin
    a_vld_d = rd_acc;
    a_err_d = ~in_range;
    b_vld_d = a_vld_q;
    b_err_d = a_err_q;
    err_d   = err_q | (accept & ~in_range);
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    wr_d  = push ? ptr_inc(wr_q) : wr_q;
    rd_d  = pop ? ptr_inc(rd_q) : rd_q;
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      addr_q  <= '0;
      din_q   <= '0;
      a_vld_q <= 1'b0;
      a_err_q <= 1'b0;
      b_vld_q <= 1'b0;
      b_err_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      csb_q   <= csb_d;
      web_q   <= web_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      a_vld_q <= a_vld_d;
      a_err_q <= a_err_d;
      b_vld_q <= b_vld_d;
      b_err_q <= b_err_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  // Capture dout at T2; out-of-range reads enqueue zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      merr_q <= '0;
    end else if (push) begin
      mem_q[wr_q]  <= b_err_q ? '0 : sram_dout;
      merr_q[wr_q] <= b_err_q;
    end
  end

`ifdef SRAM_CTRL_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] st_cnt_q, st_cnt_d;

  // Saturating activity counters.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    st_cnt_d = st_cnt_q;
    if (rd_acc && in_range && rd_cnt_q != '1)
      rd_cnt_d = rd_cnt_q + 1'b1;
    if (accept && req_we && in_range && wr_cnt_q != '1)
      wr_cnt_d = wr_cnt_q + 1'b1;
    if (req_valid && !req_ready && st_cnt_q != '1)
      st_cnt_d = st_cnt_q + 1'b1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  assign stat_rd_cnt    = rd_cnt_q;
  assign stat_wr_cnt    = wr_cnt_q;
  assign stat_stall_cnt = st_cnt_q;
`else
  assign stat_rd_cnt    = '0;
  assign stat_wr_cnt    = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb_sram_port_ctrl: directed vectors and corner sequences
// for sram_port_ctrl against a behavioural SRAM macro model.
module tb_sram_port_ctrl;

  localparam int DW = 128;
  localparam int AW = 11;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          err_sticky;
  logic          sram_csb;
  logic          sram_web;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;
  logic [31:0]   stat_rd_cnt;
  logic [31:0]   stat_wr_cnt;
  logic [31:0]   stat_stall_cnt;

  int tests = 0;
  int fails = 0;

  sram_port_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .err_sticky(err_sticky),
    .sram_csb(sram_csb), .sram_web(sram_web),
    .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_dout(sram_dout),
    .stat_rd_cnt(stat_rd_cnt),
    .stat_wr_cnt(stat_wr_cnt),
    .stat_stall_cnt(stat_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: latch at posedge, write/read at following negedge.
  logic [DW-1:0] mem [0:2047];
  logic          m_csb, m_web;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic          preload = 1'b0;

  always @(posedge clk) begin
    m_csb  <= sram_csb;
    m_web  <= sram_web;
    m_addr <= sram_addr;
    m_din  <= sram_din;
  end

  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 2048; i++) mem[i] <= DW'(i);
    end else if (m_csb === 1'b0) begin
      if (m_web === 1'b0) mem[m_addr] <= m_din;
      else sram_dout <= mem[m_addr];
    end
  end

  typedef struct {
    string         name;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_csb;
    logic          exp_web;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(string n, logic we, int a,
                              logic [DW-1:0] wd, logic c,
                              logic w, logic e,
                              logic [DW-1:0] rd);
    vec_t v;
    v.name = n; v.we = we; v.addr = AW'(a);
    v.wdata = wd; v.exp_csb = c; v.exp_web = w;
    v.exp_err = e; v.exp_rdata = rd;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_preload();
    preload = 1'b1;
    @(negedge clk);
    #1;
    preload = 1'b0;
  endtask

  // Issue reads of addr 0..7; rsp_ready held low for `hold` cycles.
  task automatic run_reads(input int hold, input bit nodrop);
    int  issued = 0;
    int  got = 0;
    int  cyc = 0;
    int  first = -1;
    int  last = -1;
    bit  dropped = 1'b0;
    bit  acc;
    while (got < 8 && cyc < 100) begin
      rsp_ready = (cyc >= hold);
      if (hold > 0 && cyc == hold) begin
        chk("bp_accepts", DW'(issued), DW'(4));
        chk("bp_ready_low", DW'(req_ready), DW'(0));
      end
      if (issued < 8) begin
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = AW'(issued);
        if (!req_ready) dropped = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      acc = req_valid && req_ready;
      if (rsp_valid && rsp_ready) begin
        chk($sformatf("rd_order%0d", got), rsp_rdata, DW'(got));
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      tick();
      if (acc) issued++;
      cyc++;
    end
    req_valid = 1'b0;
    chk("rd_count", DW'(got), DW'(8));
    if (nodrop) begin
      chk("ready_kept", DW'(dropped), DW'(0));
      chk("rsp_back2back", DW'(last - first), DW'(7));
    end
  endtask

  initial begin
    int lat;
    int seen;

    vecs[0] = mk("wr5", 1, 5, {16{8'hA5}}, 0, 0, 0, '0);
    vecs[1] = mk("rd5", 0, 5, '0, 0, 1, 0, {16{8'hA5}});
    vecs[2] = mk("rd0", 0, 0, '0, 0, 1, 0, '0);
    vecs[3] = mk("wr1295", 1, 1295, {4{32'hDEADBEEF}}, 0, 0, 0, '0);
    vecs[4] = mk("rd1295", 0, 1295, '0, 0, 1, 0, {4{32'hDEADBEEF}});
    vecs[5] = mk("rd1296", 0, 1296, '0, 1, 1, 1, '0);
    vecs[6] = mk("rd1300", 0, 1300, '0, 1, 1, 1, '0);
    vecs[7] = mk("wr1300", 1, 1300, {16{8'h77}}, 1, 1, 0, '0);

    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    do_preload();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_csb", DW'(sram_csb), DW'(1));
    chk("rst_web", DW'(sram_web), DW'(1));
    chk("rst_rsp_valid", DW'(rsp_valid), DW'(0));
    chk("rst_req_ready", DW'(req_ready), DW'(1));
    chk("rst_err_sticky", DW'(err_sticky), DW'(0));
`ifdef SRAM_CTRL_STATS_EN
    chk("rst_stat_rd", DW'(stat_rd_cnt), DW'(0));
`endif

    run_reads(0, 1'b1);
    run_reads(10, 1'b0);
    chk("no_err_in_range", DW'(err_sticky), DW'(0));

    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      req_we    = vecs[i].we;
      req_addr  = vecs[i].addr;
      req_wdata = vecs[i].wdata;
      chk({vecs[i].name, "_ready"}, DW'(req_ready), DW'(1));
      tick();
      req_valid = 1'b0;
      chk({vecs[i].name, "_csb"}, DW'(sram_csb), DW'(vecs[i].exp_csb));
      chk({vecs[i].name, "_web"}, DW'(sram_web), DW'(vecs[i].exp_web));
      if (!vecs[i].exp_csb)
        chk({vecs[i].name, "_addr"}, DW'(sram_addr), DW'(vecs[i].addr));
      if (!vecs[i].we) begin
        tick();
        chk({vecs[i].name, "_early"}, DW'(rsp_valid), DW'(0));
        tick();
        chk({vecs[i].name, "_valid"}, DW'(rsp_valid), DW'(1));
        chk({vecs[i].name, "_rdata"}, rsp_rdata, vecs[i].exp_rdata);
        chk({vecs[i].name, "_err"}, DW'(rsp_err), DW'(vecs[i].exp_err));
        tick();
        chk({vecs[i].name, "_popped"}, DW'(rsp_valid), DW'(0));
      end else begin
        tick();
      end
    end
    chk("err_sticky_set", DW'(err_sticky), DW'(1));
    chk("mem1300_kept", mem[1300], DW'(1300));

    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = AW'(9);
    req_wdata = {16{8'h3C}};
    tick();
    chk("wa_csb", DW'(sram_csb), DW'(0));
    chk("wa_web", DW'(sram_web), DW'(0));
    req_we = 1'b0;
    chk("wa_rd_ready", DW'(req_ready), DW'(1));
    tick();
    req_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      tick();
      lat++;
      if (rsp_valid) break;
    end
    chk("war_latency", DW'(lat), DW'(2));
    chk("war_rdata", rsp_rdata, {16{8'h3C}});
    chk("war_err", DW'(rsp_err), DW'(0));
    tick();

    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = AW'(k);
      tick();
    end
    req_valid = 1'b0;
    chk("pre_rst_valid", DW'(rsp_valid), DW'(1));
    chk("pre_rst_full", DW'(req_ready), DW'(0));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_csb", DW'(sram_csb), DW'(1));
    chk("mid_rst_web", DW'(sram_web), DW'(1));
    chk("mid_rst_addr", DW'(sram_addr), DW'(0));
    chk("mid_rst_din", sram_din, DW'(0));
    chk("mid_rst_valid", DW'(rsp_valid), DW'(0));
    chk("mid_rst_rdata", rsp_rdata, DW'(0));
    chk("mid_rst_err", DW'(rsp_err), DW'(0));
    chk("mid_rst_sticky", DW'(err_sticky), DW'(0));
    chk("mid_rst_ready", DW'(req_ready), DW'(1));
`ifdef SRAM_CTRL_STATS_EN
    chk("mid_rst_stat_rd", DW'(stat_rd_cnt), DW'(0));
    chk("mid_rst_stat_wr", DW'(stat_wr_cnt), DW'(0));
    chk("mid_rst_stat_st", DW'(stat_stall_cnt), DW'(0));
`endif
    tick();
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid) seen++;
      tick();
    end
    chk("post_rst_no_rsp", DW'(seen), DW'(0));
    chk("post_rst_csb", DW'(sram_csb), DW'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
